// File: rtl/pc_pkg.sv
// Shared types and defaults for the fetch-stage program-counter unit.
package pc_pkg;

    localparam int DEF_XLEN = 32;
    localparam int DEF_INC  = 4;

    typedef enum logic [2:0] {
        SEL_HOLD,
        SEL_INC,
        SEL_BR,
        SEL_JMP,
        SEL_RET
    } pc_sel_e;

    // Return-address-stack operation request; push+pop together is a swap.
    typedef struct packed {
        logic push;
        logic pop;
    } ras_req_t;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack: push/pop/swap with sticky over/underflow flags.
module ras_stack
    import pc_pkg::*;
#(
    parameter int XLEN  = DEF_XLEN,
    parameter int DEPTH = 4
) (
    input  logic                     CLK,
    input  logic                     reset,
    input  ras_req_t                 req,
    input  logic [XLEN-1:0]          push_data,
    output logic [XLEN-1:0]          top,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [XLEN-1:0] mem [DEPTH];
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   top_idx;
    logic [PW-1:0]   wr_idx;
    logic            full;
    logic            swap;

    assign top_idx = ptr - PW'(1);
    assign top     = mem[top_idx];
    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    // A swap against an empty stack degrades to a plain push.
    assign swap    = req.push && req.pop && !empty;
    assign wr_idx  = swap ? top_idx : ptr;

    // Entry contents carry no reset; validity is tracked by count alone.
    always_ff @(posedge CLK) begin
        if (!reset && req.push)
            mem[wr_idx] <= push_data;
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            ptr       <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            case ({req.push, req.pop})
                2'b10: begin
                    ptr <= ptr + PW'(1);
                    if (full)
                        overflow <= 1'b1;
                    else
                        count <= count + CW'(1);
                end
                2'b01: begin
                    if (empty) begin
                        underflow <= 1'b1;
                    end else begin
                        ptr   <= top_idx;
                        count <= count - CW'(1);
                    end
                end
                2'b11: begin
                    if (empty) begin
                        ptr       <= ptr + PW'(1);
                        count     <= count + CW'(1);
                        underflow <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/pc_unit.sv
// Fetch-stage PC register with increment/branch/jump/call/return sequencing
// and a small return-address stack.
module pc_unit
    import pc_pkg::*;
#(
    parameter int              XLEN      = DEF_XLEN,
    parameter logic [XLEN-1:0] RESET_VEC = '0,
    parameter int              INC       = DEF_INC,
    parameter int              RAS_DEPTH = 4
) (
    input  logic                        CLK,
    input  logic                        reset,
    input  logic                        stall,
    input  logic                        branch_taken,
    input  logic [XLEN-1:0]             branch_offset,
    input  logic                        jump,
    input  logic                        call,
    input  logic                        ret,
    input  logic [XLEN-1:0]             jump_target,
    output logic [XLEN-1:0]             pc,
    output logic [XLEN-1:0]             pc_plus_inc,
    output logic [$clog2(RAS_DEPTH):0]  ras_count,
    output logic                        ras_overflow,
    output logic                        ras_underflow
);

    pc_sel_e         sel;
    ras_req_t        ras_req;
    logic [XLEN-1:0] ras_top;
    logic            ras_empty;

    assign pc_plus_inc = pc + XLEN'(INC);

    // Stall gates the stack as well, so redirects during a stall leave no trace.
    assign ras_req.push = !stall && call;
    assign ras_req.pop  = !stall && ret;

    // ret on an empty stack falls back to the call target if one is present,
    // otherwise to sequential fetch.
    always_comb begin
        sel = SEL_INC;
        if (stall)                  sel = SEL_HOLD;
        else if (ret && !ras_empty) sel = SEL_RET;
        else if (ret && call)       sel = SEL_JMP;
        else if (ret)               sel = SEL_INC;
        else if (call || jump)      sel = SEL_JMP;
        else if (branch_taken)      sel = SEL_BR;
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            pc <= RESET_VEC;
        end else begin
            case (sel)
                SEL_INC: pc <= pc_plus_inc;
                SEL_BR:  pc <= pc + branch_offset;
                SEL_JMP: pc <= jump_target;
                SEL_RET: pc <= ras_top;
                default: pc <= pc;
            endcase
        end
    end

    ras_stack #(
        .XLEN  (XLEN),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .CLK       (CLK),
        .reset     (reset),
        .req       (ras_req),
        .push_data (pc_plus_inc),
        .top       (ras_top),
        .empty     (ras_empty),
        .count     (ras_count),
        .overflow  (ras_overflow),
        .underflow (ras_underflow)
    );

endmodule
